// File: rtl/branch_pkg.sv
// Shared types for the jump resolver: condition codes,
// sequencer states and the NZCBV flag bundle.
package branch_pkg;

  typedef enum logic [3:0] {
    ALWAYS = 4'd0,
    N      = 4'd1,
    P      = 4'd2,
    V      = 4'd3,
    NV     = 4'd4,
    Z      = 4'd5,
    NZ     = 4'd6,
    C      = 4'd7,
    NC     = 4'd8,
    B      = 4'd9,
    NB     = 4'd10
  } cond_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    FETCH,
    FINISH
  } br_state_t;

  localparam logic [3:0] COND_LAST = 4'd10;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic b;
    logic v;
  } flags_t;

endpackage

// File: rtl/branch_unit_if.sv
// Memory read port used to fetch the jump target byte.
// Single outstanding req, completed by a one-cycle ack.
interface branch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code decision.
// Codes above COND_LAST are flagged illegal and never taken.
module cond_eval
  import branch_pkg::*;
(
  input  cond_t  cond_i,
  input  flags_t flags_i,
  output logic   taken_o,
  output logic   illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (1'b1)
      (cond_i == ALWAYS): taken_o = 1'b1;
      (cond_i == N):      taken_o = flags_i.n;
      (cond_i == P):      taken_o = !flags_i.n;
      (cond_i == V):      taken_o = flags_i.v;
      (cond_i == NV):     taken_o = !flags_i.v;
      (cond_i == Z):      taken_o = flags_i.z;
      (cond_i == NZ):     taken_o = !flags_i.z;
      (cond_i == C):      taken_o = flags_i.c;
      (cond_i == NC):     taken_o = !flags_i.c;
      (cond_i == B):      taken_o = flags_i.b;
      (cond_i == NB):     taken_o = !flags_i.b;
      default:            illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Jump resolver: snapshots flags, decides, fetches the
// target byte when taken, then strobes a PC load.
module branch_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cond,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              c_in,
  input  logic              b_in,
  input  logic              v_in,
  input  logic [ADDR_W-1:0] pc_in,
  branch_unit_if.master     mem,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              taken,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ACK_TIMEOUT - 1);

  br_state_t         state_q, state_d;
  cond_t             cond_q, cond_d;
  flags_t            flags_q, flags_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pcn_q, pcn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              tk_q, tk_d;
  logic              done_q, done_d;
  logic              load_q, load_d;
  logic              err_q, err_d;

  logic              ev_taken;
  logic              ev_illegal;
  logic [DATA_W-1:0] rdata;

  assign rdata = mem.mem_rdata;

  cond_eval u_eval (
    .cond_i    (cond_q),
    .flags_i   (flags_q),
    .taken_o   (ev_taken),
    .illegal_o (ev_illegal)
  );

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    flags_d = flags_q;
    pc_d    = pc_q;
    pcn_d   = pcn_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    tk_d    = tk_q;
    done_d  = 1'b0;
    load_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cond_d  = cond_t'(cond);
          flags_d = '{n: n_in, z: z_in, c: c_in,
                      b: b_in, v: v_in};
          pc_d    = pc_in;
          tk_d    = 1'b0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        tk_d  = ev_taken;
        cnt_d = '0;
        if (ev_taken) begin
          req_d   = 1'b1;
          state_d = FETCH;
        end else begin
          pcn_d   = pc_q + ADDR_W'(1);
          done_d  = 1'b1;
          load_d  = 1'b1;
          err_d   = ev_illegal;
          state_d = FINISH;
        end
      end
      FETCH: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          pcn_d   = ADDR_W'(rdata);
          done_d  = 1'b1;
          load_d  = 1'b1;
          state_d = FINISH;
        end else if (cnt_q == CNT_LAST) begin
          // Abort: report done/err but leave the PC alone
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cond_q  <= ALWAYS;
      flags_q <= '0;
      pc_q    <= '0;
      pcn_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      tk_q    <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
      pc_q    <= pc_d;
      pcn_q   <= pcn_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      tk_q    <= tk_d;
      done_q  <= done_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc_q;
  assign pc_load      = load_q;
  assign pc_next      = pcn_q;
  assign taken        = tk_q;
  assign done         = done_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a cycle-timeline
// reference model and a per-cycle compare process.
module tb_branch_unit;
  import branch_pkg::*;

  localparam int TO = 15;
  localparam int DEPTH = 2048;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cond = 4'h0;
  logic       n_in = 1'b0, z_in = 1'b0, c_in = 1'b0;
  logic       b_in = 1'b0, v_in = 1'b0;
  logic [7:0] pc_in = 8'h00;
  logic       pc_load, taken, done, busy, err;
  logic [7:0] pc_next;

  branch_unit_if #(.ADDR_W(8), .DATA_W(8)) mem ();

  branch_unit #(
    .ADDR_W(8), .DATA_W(8), .ACK_TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cond    (cond),
    .n_in    (n_in),
    .z_in    (z_in),
    .c_in    (c_in),
    .b_in    (b_in),
    .v_in    (v_in),
    .pc_in   (pc_in),
    .mem     (mem),
    .pc_load (pc_load),
    .pc_next (pc_next),
    .taken   (taken),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Expected outputs per cycle number
  bit       e_req [DEPTH];
  bit       e_done[DEPTH];
  bit       e_load[DEPTH];
  bit       e_err [DEPTH];
  bit       e_busy[DEPTH];
  bit       e_tk  [DEPTH];
  logic [7:0] e_pcn [DEPTH];
  logic [7:0] e_addr[DEPTH];

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic decide(input logic [3:0] cc, input logic [4:0] f,
                        output bit tk, output bit ill);
    bit fn, fz, fc, fb, fv;
    {fn, fz, fc, fb, fv} = f;
    ill = 1'b0;
    case (int'(cc))
      0:  tk = 1'b1;
      1:  tk = fn;
      2:  tk = !fn;
      3:  tk = fv;
      4:  tk = !fv;
      5:  tk = fz;
      6:  tk = !fz;
      7:  tk = fc;
      8:  tk = !fc;
      9:  tk = fb;
      10: tk = !fb;
      default: begin tk = 1'b0; ill = 1'b1; end
    endcase
  endtask

  // k = ack wait cycles in FETCH, -1 = never acked
  task automatic plan(input int s, input logic [3:0] cc,
                      input logic [4:0] f, input logic [7:0] pc,
                      input int k, input logic [7:0] rd,
                      output int d);
    bit tk, ill;
    decide(cc, f, tk, ill);
    if (!tk) begin
      d = s + 2;
      e_load[d] = 1'b1;
      e_pcn[d]  = pc + 8'd1;
      e_err[d]  = ill;
    end else if (k >= 0 && k < TO) begin
      for (int i = s + 2; i <= s + 2 + k; i++) begin
        e_req[i] = 1'b1; e_addr[i] = pc;
      end
      d = s + 3 + k;
      e_load[d] = 1'b1;
      e_pcn[d]  = rd;
    end else begin
      for (int i = s + 2; i <= s + 1 + TO; i++) begin
        e_req[i] = 1'b1; e_addr[i] = pc;
      end
      d = s + 2 + TO;
      e_err[d] = 1'b1;
    end
    for (int i = s + 1; i <= d; i++) e_busy[i] = 1'b1;
    e_done[d] = 1'b1;
    e_tk[d]   = tk;
  endtask

  always @(negedge clk) begin
    check("busy", busy, e_busy[cyc]);
    check("mem_req", mem.mem_req, e_req[cyc]);
    check("done", done, e_done[cyc]);
    check("pc_load", pc_load, e_load[cyc]);
    check("err", err, e_err[cyc]);
    if (e_req[cyc]) check("mem_addr", mem.mem_addr, e_addr[cyc]);
    if (e_done[cyc]) check("taken", taken, e_tk[cyc]);
    if (e_load[cyc]) check("pc_next", pc_next, e_pcn[cyc]);
  end

  int n_done = 0;
  int last_d = 0;
  logic [7:0] last_pcn;
  logic last_tk, last_err, last_load;
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      last_d = cyc;
      last_pcn = pc_next;
      last_tk = taken;
      last_err = err;
      last_load = pc_load;
    end
  end

  task automatic go(input logic [3:0] cc, input logic [4:0] f,
                    input logic [7:0] pc, input int k,
                    input logic [7:0] rd, input bit again,
                    output int s);
    int d;
    @(negedge clk);
    s = cyc;
    start = 1'b1; cond = cc; pc_in = pc;
    {n_in, z_in, c_in, b_in, v_in} = f;
    plan(s, cc, f, pc, k, rd, d);
    @(negedge clk);
    start = again; cond = 4'hF; pc_in = ~pc;
    {n_in, z_in, c_in, b_in, v_in} = ~f;
    if (again) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (k >= 0) begin
      while (cyc < s + 2 + k) @(negedge clk);
      mem.mem_ack = 1'b1; mem.mem_rdata = rd;
      @(negedge clk);
      mem.mem_ack = 1'b0; mem.mem_rdata = ~rd;
    end
    while (cyc <= d) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
    $fatal(1, "timeout");
  end

  logic [3:0] lc [8] = '{4'd1, 4'd3, 4'd4, 4'd6,
                         4'd8, 4'd9, 4'd0, 4'hB};
  logic [4:0] lf [8] = '{5'b10000, 5'b00001, 5'b00001, 5'b01000,
                         5'b00000, 5'b00010, 5'b11111, 5'b11111};
  int lk [8] = '{1, 0, 0, 0, 3, 1, TO - 1, 0};

  initial begin
    int s, nd;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = 8'h00;
    #1 reset = 1'b0;
    #1;
    check("rst_mem_req", mem.mem_req, 8'h0);
    check("rst_mem_addr", mem.mem_addr, 8'h00);
    check("rst_pc_next", pc_next, 8'h00);
    check("rst_done", done, 8'h0);
    check("rst_busy", busy, 8'h0);
    check("rst_err", err, 8'h0);
    check("rst_pc_load", pc_load, 8'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Stray ack while idle must not trigger anything
    @(negedge clk);
    mem.mem_ack = 1'b1; mem.mem_rdata = 8'hEE;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_ndone", 8'(n_done), 8'd0);

    go(4'd5, 5'b00000, 8'h20, -1, 8'h00, 1'b0, s);
    check("nt_pcn", last_pcn, 8'h21);
    check("nt_lat", 8'(last_d - s), 8'd2);
    check("nt_taken", last_tk, 8'h0);

    go(4'd7, 5'b00100, 8'h40, 0, 8'h9A, 1'b0, s);
    check("tk_pcn", last_pcn, 8'h9A);
    check("tk_lat", 8'(last_d - s), 8'd3);
    check("tk_taken", last_tk, 8'h1);

    go(4'd2, 5'b00000, 8'hFF, 2, 8'h05, 1'b0, s);
    check("snap_pcn", last_pcn, 8'h05);
    check("snap_lat", 8'(last_d - s), 8'd5);
    check("snap_taken", last_tk, 8'h1);

    go(4'd10, 5'b00010, 8'hFF, -1, 8'h00, 1'b0, s);
    check("wrap_pcn", last_pcn, 8'h00);

    nd = n_done;
    go(4'hC, 5'b00000, 8'h70, -1, 8'h00, 1'b1, s);
    repeat (3) @(negedge clk);
    check("ill_err", last_err, 8'h1);
    check("ill_taken", last_tk, 8'h0);
    check("ill_pcn", last_pcn, 8'h71);
    check("ill_ndone", 8'(n_done - nd), 8'd1);

    go(4'd0, 5'b00000, 8'h88, -1, 8'h00, 1'b0, s);
    check("to_lat", 8'(last_d - s), 8'(TO + 2));
    check("to_err", last_err, 8'h1);
    check("to_load", last_load, 8'h0);

    for (int i = 0; i < 8; i++)
      go(lc[i], lf[i], 8'h50 + 8'(i), lk[i], 8'h10 + 8'(i),
         1'b0, s);

    // Async reset in the middle of FETCH
    nd = n_done;
    @(negedge clk);
    s = cyc;
    start = 1'b1; cond = 4'd0; pc_in = 8'h33;
    begin
      int d;
      plan(s, 4'd0, 5'b00000, 8'h33, -1, 8'h00, d);
    end
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = cyc; i < DEPTH; i++) begin
      e_req[i] = 1'b0; e_done[i] = 1'b0; e_load[i] = 1'b0;
      e_err[i] = 1'b0; e_busy[i] = 1'b0; e_tk[i] = 1'b0;
    end
    #1;
    check("mid_rst_req", mem.mem_req, 8'h0);
    check("mid_rst_busy", busy, 8'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (TO + 4) @(negedge clk);
    check("mid_rst_ndone", 8'(n_done - nd), 8'd0);

    go(4'd0, 5'b00000, 8'h60, 1, 8'hC3, 1'b0, s);
    check("post_rst_pcn", last_pcn, 8'hC3);
    check("post_rst_lat", 8'(last_d - s), 8'd4);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer side of the CPU's NZCBV status flags. It resolves the conditional and unconditional jumps: JMP, JN, JP, JV, JNV, JZ, JNZ, JC, JNC, JB, JNB.
- On start it snapshots the flags and evaluates the condition code.
- If the branch is taken, it fetches the target byte from memory over a req/ack handshake.
- It then issues a single-cycle PC load to the program counter.

Parameters:
- ADDR_W, 8: PC and memory address width.
- DATA_W, 8: memory data width; must equal ADDR_W.
- ACK_TIMEOUT, 15: maximum cycles to wait for mem_ack before aborting; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the control unit; honoured only in IDLE.
- cond  in  4  condition code, a cond_t value.
- n_in, z_in, c_in, b_in, v_in  in  1 each  current status flag outputs.
- pc_in  in  ADDR_W  PC value, pointing at the jump operand byte.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address; equals the captured pc_in.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  read data, the jump target.
- pc_load  out  1  one-cycle PC write strobe.
- pc_next  out  ADDR_W  new PC value; valid while pc_load=1.
- taken  out  1  branch decision; valid while done=1.
- done  out  1  one-cycle completion pulse; coincides with pc_load on a normal finish.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on an illegal cond code or an ack timeout; coincides with done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including mem_req, pc_next and mem_addr.
  - Internal registers cleared.
- States: IDLE, EVAL, FETCH, FINISH.
- IDLE:
  - On start=1 at edge T, capture cond, the five flags and pc_in, then go to EVAL at T+1.
  - start while busy is ignored; there is no queuing.
- EVAL (one cycle), decision from the captured values only:
  - ALWAYS→1, N→n, P→!n, V→v, NV→!v, Z→z, NZ→!z, C→c, NC→!c, B→b, NB→!b.
  - Codes 0xB–0xF are illegal: treated as not taken, and err is set for FINISH.
  - Taken: go to FETCH, assert mem_req at T+2, mem_addr=captured pc.
  - Not taken: go to FINISH with pc_next = captured pc + 1, wrapping modulo 2^ADDR_W (0xFF→0x00).
- FETCH:
  - mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack at edge A: register mem_rdata into pc_next, deassert mem_req at A+1, go to FINISH.
  - A wait counter starts at 0 on entry and increments each FETCH cycle without ack.
  - If the counter reaches ACK_TIMEOUT with no ack: drop mem_req, go to FINISH with taken=1, err=1, and no pc_load (the PC is left unchanged).
  - mem_ack outside FETCH is ignored.
- FINISH (one cycle):
  - done=1.
  - pc_load=1 unless aborted by timeout.
  - err as set earlier.
  - Next state IDLE.
  - busy=0 from the following cycle; a new start is accepted then.
- Latency, start edge to done:
  - Not taken or illegal code: 2 cycles.
  - Taken with ack in the first FETCH cycle: 3 cycles.
  - Each extra ack wait cycle adds 1.
- Flag changes after the start edge do not affect the decision.
- Reset mid-FETCH: mem_req drops immediately (asynchronously); no done and no pc_load.
- Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Package branch_pkg:
  - cond_t enum (4 bits): ALWAYS=0, N=1, P=2, V=3, NV=4, Z=5, NZ=6, C=7, NC=8, B=9, NB=10.
  - br_state_t enum: IDLE, EVAL, FETCH, FINISH.
  - COND_LAST=10 constant.
- Sub-module cond_eval: combinational decision. Inputs are cond_t and the flags; outputs are taken and illegal. It is reused by the decoder bench.
- All sequencing stays in branch_unit.

Test Plan:
- Not taken:
  - Stimulus: cond=Z, flags NZCBV=00000, pc_in=0x20, start.
  - Response: 2 cycles later done=1, pc_load=1, pc_next=0x21, taken=0, mem_req never asserted.
- Taken, zero-wait ack:
  - Stimulus: cond=C, flags=00100, pc_in=0x40, start; memory acks in the first FETCH cycle with 0x9A.
  - Response: mem_req=1 with mem_addr=0x40; done 3 cycles after start; pc_next=0x9A, taken=1.
- Flag snapshot and wrap-around:
  - Stimulus: cond=NN… specifically cond=P, n_in=0 at start then n_in=1 from the next cycle; pc_in=0xFF; mem_rdata=0x05 with 2-cycle ack delay.
  - Response: taken=1, pc_next=0x05, done 5 cycles after start. Separately, cond=NB with b=1 and pc_in=0xFF gives pc_next=0x00.
- Illegal code and busy:
  - Stimulus: cond=0xC, start; a second start one cycle later.
  - Response: done=1, err=1, taken=0, pc_next=pc_in+1; the second start is ignored (only one done pulse).
- Timeout:
  - Stimulus: cond=ALWAYS, mem_ack held 0.
  - Response: mem_req high for exactly ACK_TIMEOUT cycles, then done=1, err=1, pc_load=0.
- Reset mid-operation:
  - Stimulus: reset=0 asserted during FETCH, then released.
  - Response: mem_req=0 immediately; busy=0; no done; the next start behaves normally.
